tetris_game_sequencer: RTL and testbench
========================================

# tetris_game_sequencer

Top-level game-flow controller for the Tetris playfield. It drives the shared 3-bit phase code that every row block decodes (spawn, fall, key move, write, clear-shift). It schedules gravity drops from a cycle timer and arbitrates keyboard moves against gravity. It also scans full rows for clearing, counts cleared lines and halts the game on spawn collision.

## Interface
Parameters:
- ROWS, 20, playfield height; row 0 top, ROWS-1 bottom
- DROP_PERIOD, 50_000_000, cycles between gravity ticks at level 0
- DROP_STEP, 4_000_000, period reduction per level
- DROP_MIN, 5_000_000, period floor
- Local: RW = $clog2(ROWS), CW = $clog2(DROP_PERIOD+1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  restart pulse, honoured only in HALT
- keycode  in  8  keyboard keycode, 0 = none; held while key is down
- stop  in  1  OR of all row blocks' stop: the falling block collides on the next drop
- endgame  in  1  OR of all row blocks' endgame flags
- rows_full  in  ROWS  per-row full flag
- state  out  3  phase code to row blocks
- clear_row  out  RW  row being removed; valid when clear_valid = 1
- clear_valid  out  1  high exactly during SHIFT
- lines  out  16  total lines cleared, saturating at 0xFFFF
- level  out  4  lines/10, saturating at 15
- game_over  out  1  high in HALT

## Operation
Internal FSM and the output code for each state:
- BOOT (000): reset state. Next cycle goes to SPAWN.
- SPAWN (100): one cycle. Reloads the gravity counter and clears the pending key. Goes to SPAWN_CHK.
- SPAWN_CHK (000): if endgame = 1, go to HALT; otherwise go to WAIT.
- WAIT (000): gravity counter increments. Evaluation order:
  - On tick (counter == period-1): go to WRITE if stop = 1, else MOVE.
  - Else, if a key is pending: go to INPUT.
  - Else: stay in WAIT.
- MOVE (001): one cycle. Reloads counter. Goes to WAIT.
- INPUT (111): one cycle. Clears pending key. Counter keeps counting. Goes to WAIT.
- WRITE (010): one cycle. Goes to CLEAR_SCAN.
- CLEAR_SCAN (000): if rows_full != 0, latch clear_row = highest-index full row and go to SHIFT; otherwise go to SPAWN.
- SHIFT (011): one cycle with clear_valid = 1. lines increments (saturating). Goes to CLEAR_SCAN, so each full row is handled one at a time and rows_full settles for one cycle before the next scan.
- HALT (000): game_over = 1. On start = 1, clear lines, level and the counter, then go to BOOT.

Key event rules:
- A key event is registered when keycode != 0 and keycode differs from the previous cycle's keycode.
- Only 0x04 (left), 0x07 (right) and 0x1A (rotate) set key_pending; all other codes are ignored.
- A new event overwrites any pending one (the latest key wins).
- Events are latched in every state except HALT.
- SPAWN clears key_pending; an event arriving in that same cycle is also dropped.

Gravity period:
- period = max(DROP_PERIOD - level*DROP_STEP, DROP_MIN).
- Compute at CW bits; clamp on underflow.

Simultaneous events:
- Gravity tick and pending key in the same cycle: the tick wins and the key stays pending.
- start outside HALT is ignored.

## Timing
- All outputs are registered or decoded from the state register only; no input-to-output combinational paths.
- Reset values: state = 000, clear_row = 0, clear_valid = 0, lines = 0, level = 0, game_over = 0, counter = 0, key_pending = 0.
- Asynchronous reset takes effect immediately from any state, including mid-SHIFT; the FSM returns to BOOT.
- Spawn to first possible MOVE: SPAWN, then SPAWN_CHK, then WAIT for period cycles.
- Key event to INPUT: at the earliest 1 cycle after the keycode edge is sampled, provided the FSM is in WAIT.
- Landing: WRITE, then CLEAR_SCAN, then (SHIFT, CLEAR_SCAN) once per full row, then SPAWN. With no full rows this is 3 cycles.

## Configuration
- SOFT_DROP_EN:
  - Defined: keycode 0x16 (down) registers as a key event. In WAIT it forces an immediate tick (MOVE or WRITE per stop) and reloads the counter.
  - Undefined: 0x16 is ignored like any other unlisted code.

## Test plan
- Reset release with DROP_PERIOD=8, stop=0, endgame=0 -> state sequence 000, 100, 000, then 000 for 8 cycles, then 001. Repeats every 9 cycles.
- Spawn collision: endgame=1 during SPAWN_CHK -> HALT with game_over=1 and state=000 held. A start pulse -> BOOT, lines=0.
- keycode goes 0x00 to 0x07 and is held 20 cycles while in WAIT -> exactly one 111 cycle. 0x07 to 0x04 -> a second 111 cycle. A tick colliding with a pending key -> 001 first, then 111.
- stop=1 at tick with rows_full bits 19 and 17 set (bit 19 clears after its SHIFT) -> 010, 000, 011 (clear_row=19), 000, 011 (clear_row=17), 000, 100. lines=2.
- Clear 10 lines with DROP_PERIOD=100, DROP_STEP=30, DROP_MIN=50 -> level=1 and period 70; after 20 lines -> period 50 (clamped).
- SOFT_DROP_EN defined: keycode 0x16 in WAIT at counter=2 -> 001 on the next cycle and counter reloaded. Undefined -> no effect.

Source files
------------

// File: rtl/tetris_game_sequencer.sv
// Game-flow FSM for the Tetris playfield: phase codes, gravity timing, key arbitration, line clears.
// Optional build macro SOFT_DROP_EN makes keycode 0x16 force an immediate gravity tick.
module tetris_game_sequencer #(
  parameter int unsigned ROWS        = 20,
  parameter int unsigned DROP_PERIOD = 50_000_000,
  parameter int unsigned DROP_STEP   = 4_000_000,
  parameter int unsigned DROP_MIN    = 5_000_000,
  localparam int unsigned RW = $clog2(ROWS),
  localparam int unsigned CW = $clog2(DROP_PERIOD + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [7:0]      keycode,
  input  logic            stop,
  input  logic            endgame,
  input  logic [ROWS-1:0] rows_full,
  output logic [2:0]      state,
  output logic [RW-1:0]   clear_row,
  output logic            clear_valid,
  output logic [15:0]     lines,
  output logic [3:0]      level,
  output logic            game_over
);

`ifdef SOFT_DROP_EN
  localparam bit SoftDropEn = 1'b1;
`else
  localparam bit SoftDropEn = 1'b0;
`endif

  // Headroom so level*DROP_STEP cannot wrap before the underflow clamp.
  localparam int unsigned PW = CW + 4;

  typedef enum logic [3:0] {
    StBoot, StSpawn, StSpawnChk, StWait, StMove, StInput, StWrite, StClearScan, StShift, StHalt
  } st_e;

  st_e           state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [RW-1:0] clear_row_d, clear_row_q;
  logic [15:0]   lines_d, lines_q;
  logic [3:0]    level_d, level_q;
  logic [3:0]    dec_d, dec_q;
  logic [7:0]    key_prev_d, key_prev_q;
  logic          key_pend_d, key_pend_q;
  logic          key_soft_d, key_soft_q;

  logic [PW-1:0] reduce, raw;
  logic [CW-1:0] period;
  logic          tick, is_soft, key_valid, key_evt, soft_take;
  logic [RW-1:0] full_idx;

  always_comb begin
    reduce = PW'(level_q) * PW'(DROP_STEP);
    raw    = PW'(DROP_PERIOD) - reduce;
    if (reduce > PW'(DROP_PERIOD) || raw < PW'(DROP_MIN)) begin
      period = CW'(DROP_MIN);
    end else begin
      period = CW'(raw);
    end
  end

  assign tick      = (cnt_q == period - CW'(1));
  assign is_soft   = SoftDropEn && (keycode == 8'h16);
  assign key_valid = (keycode == 8'h04) || (keycode == 8'h07) || (keycode == 8'h1A) || is_soft;
  assign key_evt   = key_valid && (keycode != key_prev_q);
  assign soft_take = key_pend_q && key_soft_q && !tick;

  // Last assignment wins, so this yields the highest-index (bottom-most) full row.
  always_comb begin
    full_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (rows_full[i]) full_idx = RW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clear_row_d = clear_row_q;
    lines_d     = lines_q;
    level_d     = level_q;
    dec_d       = dec_q;
    key_prev_d  = keycode;
    key_pend_d  = key_pend_q;
    key_soft_d  = key_soft_q;
    unique case (state_q)
      StBoot:     state_d = StSpawn;
      StSpawn: begin
        cnt_d      = '0;
        key_pend_d = 1'b0;
        state_d    = StSpawnChk;
      end
      StSpawnChk: state_d = endgame ? StHalt : StWait;
      StWait: begin
        cnt_d = cnt_q + CW'(1);
        if (tick || soft_take) begin
          state_d = stop ? StWrite : StMove;
          if (soft_take) begin
            cnt_d      = '0;
            key_pend_d = 1'b0;
          end
        end else if (key_pend_q) begin
          state_d = StInput;
        end
      end
      StMove: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StInput: begin
        cnt_d      = cnt_q + CW'(1);
        key_pend_d = 1'b0;
        state_d    = StWait;
      end
      StWrite:    state_d = StClearScan;
      StClearScan: begin
        if (|rows_full) begin
          clear_row_d = full_idx;
          state_d     = StShift;
        end else begin
          state_d = StSpawn;
        end
      end
      StShift: begin
        if (lines_q != 16'hFFFF) begin
          lines_d = lines_q + 16'd1;
          if (dec_q == 4'd9) begin
            dec_d = '0;
            if (level_q != 4'hF) level_d = level_q + 4'd1;
          end else begin
            dec_d = dec_q + 4'd1;
          end
        end
        state_d = StClearScan;
      end
      StHalt: begin
        if (start) begin
          lines_d = '0;
          level_d = '0;
          dec_d   = '0;
          cnt_d   = '0;
          state_d = StBoot;
        end
      end
      default: state_d = StBoot;
    endcase
    // Latest key wins, except SPAWN drops it and HALT ignores keys entirely.
    if (key_evt && state_q != StHalt && state_q != StSpawn) begin
      key_pend_d = 1'b1;
      key_soft_d = is_soft;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StBoot;
      cnt_q       <= '0;
      clear_row_q <= '0;
      lines_q     <= '0;
      level_q     <= '0;
      dec_q       <= '0;
      key_prev_q  <= '0;
      key_pend_q  <= 1'b0;
      key_soft_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clear_row_q <= clear_row_d;
      lines_q     <= lines_d;
      level_q     <= level_d;
      dec_q       <= dec_d;
      key_prev_q  <= key_prev_d;
      key_pend_q  <= key_pend_d;
      key_soft_q  <= key_soft_d;
    end
  end

  always_comb begin
    unique case (state_q)
      StSpawn: state = 3'b100;
      StMove:  state = 3'b001;
      StInput: state = 3'b111;
      StWrite: state = 3'b010;
      StShift: state = 3'b011;
      default: state = 3'b000;
    endcase
  end

  assign clear_row   = clear_row_q;
  assign clear_valid = (state_q == StShift);
  assign lines       = lines_q;
  assign level       = level_q;
  assign game_over   = (state_q == StHalt);

endmodule

// File: tb/tb_tetris_game_sequencer.sv
// Directed bench for tetris_game_sequencer: expected phase codes are queued and checked cycle by cycle.
module tb_tetris_game_sequencer;
  localparam int unsigned ROWS = 20;
  localparam int unsigned RW   = 5;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [7:0]      keycode = 8'h00;
  logic            stop = 1'b0;
  logic            endgame = 1'b0;
  logic [ROWS-1:0] rows_full = '0;
  logic [2:0]      state;
  logic [RW-1:0]   clear_row;
  logic            clear_valid;
  logic [15:0]     lines;
  logic [3:0]      level;
  logic            game_over;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  tetris_game_sequencer #(
    .ROWS       (ROWS),
    .DROP_PERIOD(100),
    .DROP_STEP  (30),
    .DROP_MIN   (50)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .keycode    (keycode),
    .stop       (stop),
    .endgame    (endgame),
    .rows_full  (rows_full),
    .state      (state),
    .clear_row  (clear_row),
    .clear_valid(clear_valid),
    .lines      (lines),
    .level      (level),
    .game_over  (game_over)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] st, input int n);
    repeat (n) exp_q.push_back({st, 1'b0, 5'd0});
  endtask

  task automatic push_shift(input logic [4:0] row);
    exp_q.push_back({3'b011, 1'b1, row});
  endtask

  // clear_row is only meaningful while clear_valid is high.
  task automatic drain();
    logic [8:0] e;
    logic [8:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = {state, clear_valid, clear_valid ? clear_row : 5'd0};
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL seq got %h exp %h", o, e);
      end
      step();
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, expv);
    end
  endtask

  initial begin
    #1;
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_row", 16'(clear_row), 16'd0);
    chk("rst_cv", 16'(clear_valid), 16'd0);
    chk("rst_lines", lines, 16'd0);
    chk("rst_level", 16'(level), 16'd0);
    chk("rst_go", 16'(game_over), 16'd0);
    step();
    reset_n = 1'b1;

    // Boot, spawn, then two gravity periods of 100 cycles.
    push(3'd0, 1); push(3'b100, 1); push(3'd0, 1);
    push(3'd0, 100); push(3'b001, 1);
    push(3'd0, 100); push(3'b001, 1);
    drain();

    // Held key gives one INPUT; a changed key gives another.
    keycode = 8'h07;
    push(3'd0, 2); push(3'b111, 1); push(3'd0, 17);
    drain();
    keycode = 8'h04;
    push(3'd0, 2); push(3'b111, 1); push(3'd0, 1);
    drain();

    // Release key; start outside HALT must be ignored.
    keycode = 8'h00;
    start   = 1'b1;
    push(3'd0, 74);
    drain();
    start = 1'b0;

    // Key pending on the tick cycle: MOVE first, then INPUT.
    keycode = 8'h1A;
    push(3'd0, 2); push(3'b001, 1); push(3'd0, 1); push(3'b111, 1);
    drain();

    // Down key at counter 2.
    keycode = 8'h16;
`ifdef SOFT_DROP_EN
    push(3'd0, 2); push(3'b001, 1); push(3'd0, 100); push(3'b001, 1);
`else
    push(3'd0, 98); push(3'b001, 1);
`endif
    drain();
    keycode = 8'h00;

    // Landing with rows 19 and 17 full.
    stop = 1'b1;
    rows_full[19] = 1'b1;
    rows_full[17] = 1'b1;
    push(3'd0, 100); push(3'b010, 1); push(3'd0, 1); push_shift(5'd19);
    drain();
    stop = 1'b0;
    rows_full = '0;
    rows_full[17] = 1'b1;
    push(3'd0, 1); push_shift(5'd17);
    drain();
    rows_full = '0;
    push(3'd0, 1); push(3'b100, 1); push(3'd0, 1);
    drain();
    chk("lines2", lines, 16'd2);
    chk("level0", 16'(level), 16'd0);

    // Eight more lines -> level 1, period 70.
    stop = 1'b1;
    rows_full = '0;
    rows_full[0] = 1'b1;
    push(3'd0, 100); push(3'b010, 1);
    repeat (8) begin
      push(3'd0, 1); push_shift(5'd0);
    end
    drain();
    rows_full = '0;
    stop = 1'b0;
    push(3'd0, 1); push(3'b100, 1); push(3'd0, 1);
    drain();
    chk("lines10", lines, 16'd10);
    chk("level1", 16'(level), 16'd1);
    push(3'd0, 70); push(3'b001, 1);
    drain();

    // Ten more lines -> level 2, period clamped to 50.
    stop = 1'b1;
    rows_full[0] = 1'b1;
    push(3'd0, 70); push(3'b010, 1);
    repeat (10) begin
      push(3'd0, 1); push_shift(5'd0);
    end
    drain();
    rows_full = '0;
    stop = 1'b0;
    push(3'd0, 1); push(3'b100, 1); push(3'd0, 1);
    drain();
    chk("lines20", lines, 16'd20);
    chk("level2", 16'(level), 16'd2);
    push(3'd0, 50); push(3'b001, 1);
    drain();

    // Spawn collision -> HALT.
    stop = 1'b1;
    push(3'd0, 50); push(3'b010, 1); push(3'd0, 1); push(3'b100, 1);
    drain();
    endgame = 1'b1;
    stop    = 1'b0;
    push(3'd0, 6);
    drain();
    chk("halt_go", 16'(game_over), 16'd1);
    chk("halt_lines", lines, 16'd20);

    // Restart from HALT.
    start   = 1'b1;
    endgame = 1'b0;
    push(3'd0, 2); push(3'b100, 1); push(3'd0, 1);
    drain();
    start = 1'b0;
    chk("restart_lines", lines, 16'd0);
    chk("restart_level", 16'(level), 16'd0);
    chk("restart_go", 16'(game_over), 16'd0);
    push(3'd0, 100); push(3'b001, 1);
    drain();

    // Asynchronous reset in the middle of SHIFT.
    stop = 1'b1;
    rows_full[5] = 1'b1;
    push(3'd0, 100); push(3'b010, 1); push(3'd0, 1);
    drain();
    chk("shift_cv", 16'(clear_valid), 16'd1);
    chk("shift_row", 16'(clear_row), 16'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_state", 16'(state), 16'd0);
    chk("arst_cv", 16'(clear_valid), 16'd0);
    chk("arst_row", 16'(clear_row), 16'd0);
    chk("arst_lines", lines, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
